// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: pin sync, clock deglitch, 11-bit frame capture and
// scan code set 2 prefix decoding into make/break key events.
module ps2_keyboard_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 24000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic        r_fclk, r_fall, r_fbit;
  logic [7:0]  r_fcnt;
  logic [15:0] r_tcnt;
  logic [7:0]  r_shift;
  logic [2:0]  r_bitcnt;
  logic        r_par;
  logic        r_byte_valid, r_frame_err;
  logic        w_bv_nxt, w_err_nxt, w_tout;
  logic        r_ext, r_brk;
  logic [2:0]  r_skip;
  logic        r_key_strobe, r_key_pressed, r_key_extended;
  logic [7:0]  r_key_code;

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
           (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // The filtered level only moves after FILTER_LEN agreeing samples; the
  // data bit is captured on the same edge that raises the fall pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_fclk   <= 1'b1;
      r_fcnt   <= '0;
      r_fall   <= 1'b0;
      r_fbit   <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      if (r_clk_s2 != r_fclk) begin
        if (r_fcnt == 8'(FILTER_LEN - 1)) begin
          r_fclk <= r_clk_s2;
          r_fcnt <= '0;
          r_fall <= r_fclk;
          r_fbit <= r_dat_s2;
        end else begin
          r_fcnt <= r_fcnt + 8'd1;
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign w_tout = (r_state != S_IDLE) && !r_fall && (r_tcnt == 16'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_bv_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE:   if (r_fall && !r_fbit) w_state_nxt = S_DATA;
      S_DATA:   if (r_fall && r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
      S_PARITY: if (r_fall) w_state_nxt = S_STOP;
      S_STOP: begin
        if (r_fall) begin
          w_state_nxt = S_IDLE;
          if (r_fbit && (^{r_shift, r_par})) w_bv_nxt = 1'b1;
          else w_err_nxt = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_tout) begin
      w_state_nxt = S_IDLE;
      w_bv_nxt    = 1'b0;
      w_err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt       <= '0;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_par        <= 1'b0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_bv_nxt;
      r_frame_err  <= w_err_nxt;
      if (r_state == S_IDLE || r_fall || w_tout) r_tcnt <= '0;
      else                                       r_tcnt <= r_tcnt + 16'd1;
      if (r_state == S_IDLE) r_bitcnt <= '0;
      if (r_state == S_DATA && r_fall) begin
        r_shift  <= {r_fbit, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (r_state == S_PARITY && r_fall) r_par <= r_fbit;
    end
  end

  // Prefix decoder: E1 swallows the remaining seven Pause bytes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext          <= 1'b0;
      r_brk          <= 1'b0;
      r_skip         <= '0;
      r_key_strobe   <= 1'b0;
      r_key_pressed  <= 1'b0;
      r_key_extended <= 1'b0;
      r_key_code     <= '0;
    end else begin
      r_key_strobe <= 1'b0;
      if (r_frame_err) begin
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
        r_skip <= '0;
      end else if (r_byte_valid) begin
        if (r_skip != 3'd0) begin
          r_skip <= r_skip - 3'd1;
        end else if (r_shift == 8'hE1) begin
          r_skip <= 3'd7;
          r_ext  <= 1'b0;
          r_brk  <= 1'b0;
        end else if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk <= 1'b1;
        end else if (is_ctrl(r_shift) ||
                     (r_ext && (r_shift == 8'h12 || r_shift == 8'h59))) begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end else begin
          r_key_code     <= r_shift;
          r_key_pressed  <= ~r_brk;
          r_key_extended <= r_ext;
          r_key_strobe   <= 1'b1;
          r_ext          <= 1'b0;
          r_brk          <= 1'b0;
        end
      end
    end
  end

  assign key_strobe   = r_key_strobe;
  assign key_pressed  = r_key_pressed;
  assign key_extended = r_key_extended;
  assign key_code     = r_key_code;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Scoreboard bench: driver pushes expected key/error events from a byte-level
// decoder model; a monitor pops and compares on every strobe or error pulse.
module tb_ps2_keyboard_decoder;
  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_strobe, key_pressed, key_extended, frame_err;
  logic [7:0] key_code;

  ps2_keyboard_decoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_strobe(key_strobe), .key_pressed(key_pressed),
    .key_extended(key_extended), .key_code(key_code), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         pressed;
    bit         ext;
    longint     due;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     tests = 0;
  int     fails = 0;
  bit     m_ext = 0, m_brk = 0;
  int     m_skip = 0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic push_err(input longint due);
    exp_t e;
    e.is_err = 1; e.code = 8'h00; e.pressed = 0; e.ext = 0; e.due = due;
    q.push_back(e);
    model_clear();
  endtask

  // Byte-level model of the decoder rules; sc is the cycle of the stop-bit fall.
  task automatic model_byte(input logic [7:0] b, input bit good, input longint sc);
    exp_t e;
    if (!good) push_err(sc + FL + 3);
    else if (m_skip != 0) m_skip--;
    else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF} ||
             (m_ext && (b == 8'h12 || b == 8'h59))) begin
      m_ext = 0; m_brk = 0;
    end else begin
      e.is_err = 0; e.code = b; e.pressed = !m_brk; e.ext = m_ext; e.due = sc + FL + 4;
      q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input bit full,
                           input logic [7:0] b, input bit good);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (full && i == 10) model_byte(b, good, cyc);
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (2 * HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs);
    logic [10:0] f;
    f = {~bs, (~^b) ^ bp, b, 1'b0};
    send_bits(f, 11, 1, b, !(bp || bs));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_strobe"},  key_strobe,   0);
    check({tag, "_pressed"}, key_pressed,  0);
    check({tag, "_ext"},     key_extended, 0);
    check({tag, "_code"},    key_code,     0);
    check({tag, "_err"},     frame_err,    0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (key_strobe && frame_err) begin
        check("strobe_err_overlap", 1, 0);
      end else if (key_strobe || frame_err) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: strobe=%0b err=%0b code=0x%0h, none expected (cycle %0d)",
                   key_strobe, frame_err, key_code, cyc);
        end else begin
          mon_e = q.pop_front();
          check("event_is_err", frame_err, mon_e.is_err);
          if (!mon_e.is_err && key_strobe) begin
            check("key_code",     key_code,     mon_e.code);
            check("key_pressed",  key_pressed,  mon_e.pressed);
            check("key_extended", key_extended, mon_e.ext);
          end
          if (mon_e.due >= 0) check("event_latency", cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d events pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] pause_seq [8];
    logic [7:0] ctrl [7];
    int r;
    bit bp, bs;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    ctrl      = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'h29, 1, 0);
    send_frame(8'h29, 0, 0);
    foreach (pause_seq[i]) send_frame(pause_seq[i], 0, 0);
    send_frame(8'h16, 0, 0);
    send_frame(8'h12, 0, 1);
    send_frame(8'h12, 0, 0);

    // Timeout: start bit plus four data bits, then the clock stops.
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5, 0, 8'h00, 0);
    push_err(-1);
    repeat (TO + 40) @(negedge clk);
    send_frame(8'h05, 0, 0);

    ps2_data = 1'b0;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_pending", q.size(), 0);
    send_frame(8'h34, 0, 0);

    send_frame(8'h66, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_bits({1'b1, 1'b0, 8'h3A, 1'b0}, 5, 0, 8'h00, 0);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midframe_reset");
    model_clear();
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h3A, 0, 0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      b = 8'hE0;
      else if (r < 18) b = 8'hF0;
      else if (r < 21) b = 8'hE1;
      else if (r < 26) b = ctrl[$urandom_range(0, 6)];
      else if (r < 29) b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
      else             b = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 99) < 6);
      bs = !bp && ($urandom_range(0, 99) < 4);
      send_frame(b, bp, bs);
    end

    repeat (100) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
